// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: issues word requests to instruction memory, holds
// each request until acknowledged, and presents the fetched instruction to
// the IF/ID register until it is accepted (stall_i low).
// Redirects (branch/jump) flush the presented instruction and retarget the
// fetch PC; a redirect that arrives while a request is outstanding is
// remembered and applied once the in-flight read returns.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          asynchronous active-low reset
//   start_i        run enable
//   stall_i        IF/ID not accepting (hold presented instruction)
//   redirect_i     flush request, redirect_pc_i is the new target
//   imem_req_o     instruction-memory request (high only in FETCH)
//   imem_addr_o    request address, 0 when no request
//   imem_ack_i     one-cycle read-complete strobe, imem_rdata_i valid with it
//   pc_o/instr_o   presented instruction and its PC
//   valid_o        pc_o/instr_o hold a live instruction
//   fetch_cnt_o    number of instructions accepted downstream
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | not running; no request, outputs cleared, pc_q retained
// FETCH | request outstanding at pc_q, waiting for imem_ack_i
// HOLD  | instruction presented on pc_o/instr_o, waiting for acceptance
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        valid_o,
   output logic [31:0] fetch_cnt_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic [31:0] tgt_q, tgt_d;        // deferred redirect target while drop_q
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] redirect_tgt;

   assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         tgt_q       <= 32'h0;
         out_pc_q    <= 32'h0;
         out_instr_q <= 32'h0;
         out_valid_q <= 1'b0;
         cnt_q       <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         tgt_q       <= tgt_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_d      = drop_q;
      tgt_d       = tgt_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (redirect_i) begin
               pc_d = redirect_tgt;
            end
            if (start_i) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            if (redirect_i) begin
               out_valid_d = 1'b0;
               out_pc_d    = 32'h0;
               out_instr_d = 32'h0;
               if (imem_ack_i) begin
                  // read completes now, so the address may move immediately
                  pc_d    = redirect_tgt;
                  drop_d  = 1'b0;
                  state_d = start_i ? FETCH : IDLE;
               end else begin
                  // address must stay put until ack; apply target afterwards
                  drop_d = 1'b1;
                  tgt_d  = redirect_tgt;
               end
            end else if (imem_ack_i) begin
               if (drop_q) begin
                  pc_d    = tgt_q;
                  drop_d  = 1'b0;
                  state_d = start_i ? FETCH : IDLE;
               end else if (!start_i) begin
                  state_d = IDLE;
               end else begin
                  out_instr_d = imem_rdata_i;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + 32'd4;
                  state_d     = HOLD;
               end
            end
         end

         HOLD: begin
            if (redirect_i) begin
               pc_d        = redirect_tgt;
               out_valid_d = 1'b0;
               out_pc_d    = 32'h0;
               out_instr_d = 32'h0;
               state_d     = start_i ? FETCH : IDLE;
            end else if (!start_i) begin
               out_valid_d = 1'b0;
               out_pc_d    = 32'h0;
               out_instr_d = 32'h0;
               state_d     = IDLE;
            end else if (!stall_i) begin
               cnt_d       = cnt_q + 32'd1;
               out_valid_d = 1'b0;
               out_pc_d    = 32'h0;
               out_instr_d = 32'h0;
               state_d     = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_req_o  = (state_q == FETCH);
   assign imem_addr_o = (state_q == FETCH) ? pc_q : 32'h0;
   assign pc_o        = out_pc_q;
   assign instr_o     = out_instr_q;
   assign valid_o     = out_valid_q;
   assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        valid_o;
   logic [31:0] fetch_cnt_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb[$];

   instr_fetch dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_rdata_i (imem_rdata_i),
      .pc_o         (pc_o),
      .instr_o      (instr_o),
      .valid_o      (valid_o),
      .fetch_cnt_o  (fetch_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // one-cycle ack strobe with data, then back to idle bus
   task automatic ack(input logic [31:0] data);
      imem_ack_i   = 1'b1;
      imem_rdata_i = data;
      tick();
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
   endtask

   // pop the scoreboard when the DUT presents an instruction
   task automatic check_out(input string tag);
      exp_t e;
      int   n = 0;
      while (!valid_o && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'h0, valid_o}, 32'h1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'h1, 32'h0 + sb.size());
      end else begin
         e = sb.pop_front();
         chk({tag, "_pc"}, pc_o, e.pc);
         chk({tag, "_instr"}, instr_o, e.instr);
      end
   endtask

   initial begin
      rst_i         = 1'b0;
      start_i       = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      imem_ack_i    = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
      tick();

      // reset state
      chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
      chk("rst_addr",  imem_addr_o, 32'h0);
      chk("rst_valid", {31'h0, valid_o}, 32'h0);
      chk("rst_pc",    pc_o, 32'h0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_cnt",   fetch_cnt_o, 32'h0);

      // first fetch, ack two cycles after request, downstream stalled
      rst_i   = 1'b1;
      tick();
      start_i = 1'b1;
      stall_i = 1'b1;
      tick();
      chk("f0_req",  {31'h0, imem_req_o}, 32'h1);
      chk("f0_addr", imem_addr_o, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("f0_addr_held", imem_addr_o, 32'h0);
      end
      sb.push_back('{pc: 32'h0, instr: 32'h0050_0093});
      ack(32'h0050_0093);
      check_out("f0");
      chk("f0_req_hold", {31'h0, imem_req_o}, 32'h0);

      // stall for three cycles: everything frozen
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", {31'h0, valid_o}, 32'h1);
         chk("stall_pc",    pc_o, 32'h0);
         chk("stall_instr", instr_o, 32'h0050_0093);
         chk("stall_req",   {31'h0, imem_req_o}, 32'h0);
         chk("stall_cnt",   fetch_cnt_o, 32'h0);
      end
      stall_i = 1'b0;
      tick();
      chk("rel_cnt",   fetch_cnt_o, 32'h1);
      chk("rel_valid", {31'h0, valid_o}, 32'h0);
      chk("rel_addr",  imem_addr_o, 32'h4);

      // zero-latency ack at 0x4
      sb.push_back('{pc: 32'h4, instr: 32'h1234_5678});
      ack(32'h1234_5678);
      check_out("f4");
      tick();
      chk("f8_addr", imem_addr_o, 32'h8);
      chk("f8_cnt",  fetch_cnt_o, 32'h2);

      // redirect while 0x8 outstanding: address held, data dropped
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      tick();
      redirect_i    = 1'b0;
      chk("rd_addr_held0", imem_addr_o, 32'h8);
      tick();
      chk("rd_addr_held1", imem_addr_o, 32'h8);
      ack(32'hBAD0_0008);
      chk("rd_valid", {31'h0, valid_o}, 32'h0);
      chk("rd_addr",  imem_addr_o, 32'h100);
      chk("rd_cnt",   fetch_cnt_o, 32'h2);

      // redirect coincident with ack while stalled
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      imem_ack_i    = 1'b1;
      imem_rdata_i  = 32'hBAD0_0100;
      tick();
      redirect_i    = 1'b0;
      imem_ack_i    = 1'b0;
      chk("rdack_valid", {31'h0, valid_o}, 32'h0);
      chk("rdack_addr",  imem_addr_o, 32'h200);
      chk("rdack_cnt",   fetch_cnt_o, 32'h2);

      // retarget to the top word and check wrap
      stall_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFF;
      tick();
      redirect_i    = 1'b0;
      chk("wr_addr_held", imem_addr_o, 32'h200);
      ack(32'hBAD0_0200);
      chk("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
      sb.push_back('{pc: 32'hFFFF_FFFC, instr: 32'hCAFE_F00D});
      ack(32'hCAFE_F00D);
      check_out("wr");
      tick();
      chk("wr_next_addr", imem_addr_o, 32'h0);
      chk("wr_cnt",       fetch_cnt_o, 32'h3);

      // asynchronous reset mid-FETCH
      #2;
      rst_i = 1'b0;
      #1;
      chk("ar_req",  {31'h0, imem_req_o}, 32'h0);
      chk("ar_addr", imem_addr_o, 32'h0);
      chk("ar_cnt",  fetch_cnt_o, 32'h0);
      start_i = 1'b0;
      tick();
      rst_i = 1'b1;
      ack(32'hBAD0_0000);
      for (int i = 0; i < 3; i++) begin
         chk("late_valid", {31'h0, valid_o}, 32'h0);
         chk("late_req",   {31'h0, imem_req_o}, 32'h0);
         tick();
      end

      // start dropped during FETCH: request held to ack, data discarded
      start_i = 1'b1;
      tick();
      chk("sd_req", {31'h0, imem_req_o}, 32'h1);
      start_i = 1'b0;
      tick();
      chk("sd_addr_held", imem_addr_o, 32'h0);
      ack(32'hBAD0_1111);
      chk("sd_req_idle", {31'h0, imem_req_o}, 32'h0);
      chk("sd_valid",    {31'h0, valid_o}, 32'h0);

      chk("sb_drained", 32'h0 + sb.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
